// File: rtl/cms_pkg.sv
// ---------------------------------------------------------------------------
// cms_pkg
// Shared definitions for the count-min sketch bank.
//  - default geometry of one sketch slice (rows, counters per row, widths)
//  - cnt_t / col_t / op_t describing one operation at the default geometry
//  - cnt_min(): unsigned minimum of two counters, zero-extended to
//    CNT_MAX_W so that every configured CNT_SIZE up to 64 can share it
// ---------------------------------------------------------------------------
package cms_pkg;

    localparam int NUM_HASH_DEF = 4;
    localparam int W_UNIT_DEF   = 4096;
    localparam int COL_W_DEF    = $clog2(W_UNIT_DEF);
    localparam int CNT_SIZE_DEF = 32;

    // Widest counter the shared min helper handles.
    localparam int CNT_MAX_W    = 64;

    typedef logic [CNT_SIZE_DEF-1:0] cnt_t;
    typedef logic [COL_W_DEF-1:0]    col_t;

    typedef struct packed {
        logic                       valid;
        logic                       query_only;
        logic                       conservative;
        col_t [NUM_HASH_DEF-1:0]    col;
    } op_t;

    function automatic logic [CNT_MAX_W-1:0] cnt_min(
        input logic [CNT_MAX_W-1:0] a,
        input logic [CNT_MAX_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cms_sdp_ram.sv
// ---------------------------------------------------------------------------
// cms_sdp_ram
// Simple dual-port counter RAM for one sketch row: one write port, one read
// port, registered (1-cycle) read. A read and a write to the same address in
// the same cycle return the OLD contents; the sketch pipeline forwards around
// that case itself. No reset and no initialisation: validity of each word is
// tracked outside the RAM.
// Ports:
//  clk       clock
//  we_i      write enable
//  waddr_i   write address
//  wdata_i   write data
//  raddr_i   read address (sampled every cycle)
//  rdata_o   read data, valid one cycle after raddr_i
// ---------------------------------------------------------------------------
module cms_sdp_ram
    import cms_pkg::*;
#(
    parameter int DEPTH = W_UNIT_DEF,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = CNT_SIZE_DEF
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/cms_sketch_unit_v2.sv
// ---------------------------------------------------------------------------
// cms_sketch_unit_v2
// Count-min sketch bank: NUM_HASH rows x W_UNIT counters. One key (one
// column index per row) per cycle. Supports query-only ops, conservative
// update, saturating or wrapping counters, same-column forwarding between
// adjacent ops, and a per-key minimum output.
//
// Pipeline (op accepted at edge E0, result visible after edge E3):
//  S0  input register
//  S1  column handed to the row RAMs and the valid-bit array
//  S2  RAM data returns; current count, new count, write-back
//  S3  output register
//
// Handshake: an op is accepted on a rising edge where in_valid && in_ready.
// in_ready drops for exactly the cycle following each sampled clear_req; an
// op offered while in_ready is low is dropped, not stalled. out_valid is a
// one-cycle strobe with no back-pressure.
//
// Ports:
//  clk, rst_n        clock, asynchronous active-low reset
//  clear_req         synchronous clear of the whole sketch
//  in_valid/in_ready op issue handshake
//  in_query_only     read counts without writing
//  in_conservative   conservative update (ignored with in_query_only)
//  in_col            NUM_HASH packed column indices, row i at [i*COL_W +: COL_W]
//  out_valid         result strobe
//  out_cnt           NUM_HASH packed counts after the op (0 when idle)
//  out_min           minimum of out_cnt (0 when idle)
// ---------------------------------------------------------------------------
module cms_sketch_unit_v2
    import cms_pkg::*;
#(
    parameter int NUM_HASH = NUM_HASH_DEF,
    parameter int W_UNIT   = W_UNIT_DEF,
    parameter int COL_W    = $clog2(W_UNIT),
    parameter int CNT_SIZE = CNT_SIZE_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_req,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_query_only,
    input  logic                         in_conservative,
    input  logic [NUM_HASH*COL_W-1:0]    in_col,
    output logic                         out_valid,
    output logic [NUM_HASH*CNT_SIZE-1:0] out_cnt,
    output logic [CNT_SIZE-1:0]          out_min
);

    logic                ready_q;
    logic                accept;

    logic                s0_vld_q, s0_qo_q, s0_cons_q;
    logic                s1_vld_q, s1_qo_q, s1_cons_q;
    logic                s2_vld_q, s2_qo_q, s2_cons_q;
    logic [COL_W-1:0]    s0_col_q [NUM_HASH];
    logic [COL_W-1:0]    s1_col_q [NUM_HASH];
    logic [COL_W-1:0]    s2_col_q [NUM_HASH];

    logic [NUM_HASH-1:0] s2_vb_q;
    logic [NUM_HASH-1:0] s2_fwd_q;
    logic [CNT_SIZE-1:0] s2_fwd_val_q [NUM_HASH];

    logic [W_UNIT-1:0]   vbit_q [NUM_HASH];
    logic [CNT_SIZE-1:0] ram_rdata [NUM_HASH];

    logic [CNT_SIZE-1:0] cur_c [NUM_HASH];
    logic [CNT_SIZE:0]   inc_w [NUM_HASH];
    logic [CNT_SIZE-1:0] cnt_d [NUM_HASH];
    logic [CNT_SIZE-1:0] c_min;
    logic [CNT_SIZE-1:0] n_min;
    logic [NUM_HASH-1:0] wr_en;

    logic                out_vld_q;
    logic [CNT_SIZE-1:0] out_cnt_q [NUM_HASH];
    logic [CNT_SIZE-1:0] out_min_q;

    assign accept   = in_valid && ready_q;
    assign in_ready = ready_q;

    // Pipeline registers. A clear empties S0..S2 so flushed ops never reach
    // the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b1;
            s0_vld_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s0_qo_q   <= 1'b0;
            s1_qo_q   <= 1'b0;
            s2_qo_q   <= 1'b0;
            s0_cons_q <= 1'b0;
            s1_cons_q <= 1'b0;
            s2_cons_q <= 1'b0;
            s2_vb_q   <= '0;
            s2_fwd_q  <= '0;
            for (int i = 0; i < NUM_HASH; i++) begin
                s0_col_q[i]     <= '0;
                s1_col_q[i]     <= '0;
                s2_col_q[i]     <= '0;
                s2_fwd_val_q[i] <= '0;
            end
        end else begin
            ready_q <= !clear_req;
            if (clear_req) begin
                s0_vld_q <= 1'b0;
                s1_vld_q <= 1'b0;
                s2_vld_q <= 1'b0;
            end else begin
                s0_vld_q <= accept;
                s1_vld_q <= s0_vld_q;
                s2_vld_q <= s1_vld_q;
            end
            s0_qo_q   <= in_query_only;
            s1_qo_q   <= s0_qo_q;
            s2_qo_q   <= s1_qo_q;
            s0_cons_q <= in_conservative;
            s1_cons_q <= s0_cons_q;
            s2_cons_q <= s1_cons_q;
            for (int i = 0; i < NUM_HASH; i++) begin
                s0_col_q[i] <= in_col[i*COL_W +: COL_W];
                s1_col_q[i] <= s0_col_q[i];
                s2_col_q[i] <= s1_col_q[i];
                // Same-cycle read of the valid bit sees the old value, just
                // like the RAM; the forward flag below covers that case.
                s2_vb_q[i]  <= vbit_q[i][s1_col_q[i]];
                // The RAM read issued this edge misses the write issued at
                // the same edge, so the next op takes the written value
                // directly.
                s2_fwd_q[i]     <= wr_en[i] && (s1_col_q[i] == s2_col_q[i]);
                s2_fwd_val_q[i] <= cnt_d[i];
            end
        end
    end

    // Per-column valid bits: a counter that was never written since reset or
    // the last clear reads as zero whatever the RAM holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_HASH; i++) begin
                vbit_q[i] <= '0;
            end
        end else if (clear_req) begin
            for (int i = 0; i < NUM_HASH; i++) begin
                vbit_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_HASH; i++) begin
                if (wr_en[i]) begin
                    vbit_q[i][s2_col_q[i]] <= 1'b1;
                end
            end
        end
    end

    // S2: current counts, minimum, new counts and write enables.
    always_comb begin
        c_min = '1;
        for (int i = 0; i < NUM_HASH; i++) begin
            cur_c[i] = s2_fwd_q[i] ? s2_fwd_val_q[i]
                                   : (s2_vb_q[i] ? ram_rdata[i] : '0);
            c_min = CNT_SIZE'(cnt_min(CNT_MAX_W'(c_min), CNT_MAX_W'(cur_c[i])));
        end
        n_min = '1;
        for (int i = 0; i < NUM_HASH; i++) begin
            // One extra bit so the carry out flags an all-ones counter.
            inc_w[i] = {1'b0, cur_c[i]} + {{CNT_SIZE{1'b0}}, 1'b1};
            cnt_d[i] = cur_c[i];
            if (!s2_qo_q && (!s2_cons_q || (cur_c[i] == c_min))) begin
                if (!(inc_w[i][CNT_SIZE] && SATURATE)) begin
                    cnt_d[i] = inc_w[i][CNT_SIZE-1:0];
                end
            end
            // A first touch writes even if the value would not change, so the
            // valid bit gets set.
            wr_en[i] = s2_vld_q && !s2_qo_q && !clear_req &&
                       ((cnt_d[i] != cur_c[i]) || !(s2_fwd_q[i] || s2_vb_q[i]));
            n_min = CNT_SIZE'(cnt_min(CNT_MAX_W'(n_min), CNT_MAX_W'(cnt_d[i])));
        end
    end

    // S3 output register; forced to zero when no result is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_min_q <= '0;
            for (int i = 0; i < NUM_HASH; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            out_vld_q <= s2_vld_q && !clear_req;
            out_min_q <= (s2_vld_q && !clear_req) ? n_min : '0;
            for (int i = 0; i < NUM_HASH; i++) begin
                out_cnt_q[i] <= (s2_vld_q && !clear_req) ? cnt_d[i] : '0;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign out_min   = out_min_q;

    for (genvar g = 0; g < NUM_HASH; g++) begin : g_row
        cms_sdp_ram #(
            .DEPTH (W_UNIT),
            .AW    (COL_W),
            .DW    (CNT_SIZE)
        ) u_ram (
            .clk     (clk),
            .we_i    (wr_en[g]),
            .waddr_i (s2_col_q[g]),
            .wdata_i (cnt_d[g]),
            .raddr_i (s1_col_q[g]),
            .rdata_o (ram_rdata[g])
        );
        assign out_cnt[g*CNT_SIZE +: CNT_SIZE] = out_cnt_q[g];
    end

endmodule
